// File: rtl/jk_modn_counter_if.sv
// Control and status bundle for one jk_modn_counter digit.
// The master drives count controls; the slave (the counter) returns count and flags.
interface jk_modn_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (output en, up_dn, load, d, input q, tc, wrap);
  modport slave  (input en, up_dn, load, d, output q, tc, wrap);
endinterface

// File: rtl/jk_modn_counter.sv
// Modulo-N up/down counter built from per-bit JK stages (j = k = toggle).
// tc is combinational for cascading; wrap is a registered one-cycle pulse.
module jk_modn_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  jk_modn_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic             wrap_next_s;
  logic             wrap_r;
  logic             at_max_s;
  logic             at_zero_s;

  assign at_max_s  = (q_s == MAX_VAL);
  assign at_zero_s = (q_s == {WIDTH{1'b0}});

  // Next-count select with priority load > en > hold
  always_comb begin
    next_s      = q_s;
    wrap_next_s = 1'b0;
    if (bus.load) begin
      if ({1'b0, bus.d} < MOD_EXT) begin
        next_s = bus.d;
      end else begin
        next_s = MAX_VAL;
      end
    end else if (bus.en) begin
      if (bus.up_dn) begin
        // Out-of-range states also fold back to zero on an up count
        if (q_s >= MAX_VAL) begin
          next_s      = {WIDTH{1'b0}};
          wrap_next_s = 1'b1;
        end else begin
          next_s = q_s + WIDTH'(1);
        end
      end else begin
        if (at_zero_s) begin
          next_s      = MAX_VAL;
          wrap_next_s = 1'b1;
        end else begin
          next_s = q_s - WIDTH'(1);
        end
      end
    end else begin
      next_s = q_s;
    end
  end

  assign j_s = q_s ^ next_s;
  assign k_s = q_s ^ next_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic stage_r;

    // JK flip-flop stage for bit i
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_r <= 1'b0;
      end else begin
        case ({j_s[i], k_s[i]})
          2'b00:   stage_r <= stage_r;
          2'b01:   stage_r <= 1'b0;
          2'b10:   stage_r <= 1'b1;
          2'b11:   stage_r <= ~stage_r;
          default: stage_r <= stage_r;
        endcase
      end
    end

    assign q_s[i] = stage_r;
  end

  // Wrap pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= wrap_next_s;
    end
  end

  assign bus.q    = q_s;
  assign bus.wrap = wrap_r;
  assign bus.tc   = bus.en & ~bus.load &
                    ((bus.up_dn & at_max_s) | (~bus.up_dn & at_zero_s));
endmodule

// File: tb/tb_jk_modn_counter.sv
// Directed bench for jk_modn_counter (WIDTH=4, MODULO=10) with a two-digit cascade.
module tb_jk_modn_counter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  jk_modn_counter_if #(.WIDTH(4)) u_if ();
  jk_modn_counter_if #(.WIDTH(4)) t_if ();

  jk_modn_counter #(.WIDTH(4), .MODULO(10)) u_units (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  jk_modn_counter #(.WIDTH(4), .MODULO(10)) u_tens (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (t_if.slave)
  );

  assign t_if.en = u_if.tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    u_if.en = 1'b0; u_if.up_dn = 1'b1; u_if.load = 1'b0; u_if.d = 4'd0;
    t_if.up_dn = 1'b1; t_if.load = 1'b0; t_if.d = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (u_if.q !== 4'd0 || u_if.wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_initial: q=%0d wrap=%b, expected q=0 wrap=0", u_if.q, u_if.wrap);
    end
    @(negedge clk); rst_n = 1'b1;
    // load 6 then count once to reach 7 mid-count
    u_if.load = 1'b1; u_if.d = 4'd6; tick();
    u_if.load = 1'b0; u_if.en = 1'b1; tick();
    n_checks++;
    if (u_if.q !== 4'd7) begin
      n_fail++; $display("FAIL reset_pre_q: q=%0d, expected 7", u_if.q);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (u_if.q !== 4'd0 || u_if.wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_q7: q=%0d wrap=%b, expected q=0 wrap=0", u_if.q, u_if.wrap);
    end
    @(negedge clk); rst_n = 1'b1; u_if.en = 1'b0;
    tick(); tick();
    n_checks++;
    if (u_if.q !== 4'd0 || u_if.wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_hold: q=%0d wrap=%b, expected q=0 wrap=0", u_if.q, u_if.wrap);
    end
    // asynchronous clear of a live wrap pulse
    u_if.load = 1'b1; u_if.d = 4'd9; tick();
    u_if.load = 1'b0; u_if.en = 1'b1; u_if.up_dn = 1'b1; tick();
    n_checks++;
    if (u_if.q !== 4'd0 || u_if.wrap !== 1'b1) begin
      n_fail++; $display("FAIL reset_wrap_pre: q=%0d wrap=%b, expected q=0 wrap=1", u_if.q, u_if.wrap);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (u_if.wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_wrap: wrap=%b, expected 0", u_if.wrap);
    end
    @(negedge clk); rst_n = 1'b1; u_if.en = 1'b0;
    tick();
  endtask

  task automatic test_up_count();
    int prev;
    int exp_q;
    prev = 0;
    u_if.en = 1'b1; u_if.up_dn = 1'b1; u_if.load = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      n_checks++;
      if (u_if.tc !== (prev == 9)) begin
        n_fail++; $display("FAIL up_tc step %0d: tc=%b, expected %b", i, u_if.tc, (prev == 9));
      end
      tick();
      exp_q = i % 10;
      n_checks++;
      if (u_if.q !== 4'(exp_q) || u_if.wrap !== (i == 10)) begin
        n_fail++; $display("FAIL up_q step %0d: q=%0d wrap=%b, expected q=%0d wrap=%b",
                           i, u_if.q, u_if.wrap, exp_q, (i == 10));
      end
      prev = exp_q;
    end
  endtask

  task automatic test_down_count();
    int exp_seq[3];
    int prev;
    exp_seq = '{0, 9, 8};
    u_if.en = 1'b0; u_if.load = 1'b1; u_if.d = 4'd1; tick();
    n_checks++;
    if (u_if.q !== 4'd1 || u_if.wrap !== 1'b0) begin
      n_fail++; $display("FAIL down_load1: q=%0d wrap=%b, expected q=1 wrap=0", u_if.q, u_if.wrap);
    end
    u_if.load = 1'b0; u_if.en = 1'b1; u_if.up_dn = 1'b0;
    prev = 1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (u_if.tc !== (prev == 0)) begin
        n_fail++; $display("FAIL down_tc step %0d: tc=%b, expected %b", i, u_if.tc, (prev == 0));
      end
      tick();
      n_checks++;
      if (u_if.q !== 4'(exp_seq[i]) || u_if.wrap !== (prev == 0)) begin
        n_fail++; $display("FAIL down_q step %0d: q=%0d wrap=%b, expected q=%0d wrap=%b",
                           i, u_if.q, u_if.wrap, exp_seq[i], (prev == 0));
      end
      prev = exp_seq[i];
    end
  endtask

  task automatic test_load();
    u_if.en = 1'b1; u_if.up_dn = 1'b1; u_if.load = 1'b1; u_if.d = 4'd5;
    #1;
    n_checks++;
    if (u_if.tc !== 1'b0) begin
      n_fail++; $display("FAIL load_tc_masked: tc=%b, expected 0", u_if.tc);
    end
    tick();
    n_checks++;
    if (u_if.q !== 4'd5 || u_if.wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_5: q=%0d wrap=%b, expected q=5 wrap=0", u_if.q, u_if.wrap);
    end
    u_if.d = 4'd13; tick();
    n_checks++;
    if (u_if.q !== 4'd9 || u_if.wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_sat13: q=%0d wrap=%b, expected q=9 wrap=0", u_if.q, u_if.wrap);
    end
    u_if.d = 4'd9;
    #1;
    n_checks++;
    if (u_if.tc !== 1'b0) begin
      n_fail++; $display("FAIL load_tc_at9: tc=%b, expected 0", u_if.tc);
    end
    tick();
    n_checks++;
    if (u_if.q !== 4'd9 || u_if.wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_9_at9: q=%0d wrap=%b, expected q=9 wrap=0", u_if.q, u_if.wrap);
    end
    u_if.load = 1'b0;
  endtask

  task automatic test_hold_direction();
    logic dir_seq[3];
    int   exp_seq[3];
    dir_seq = '{1'b1, 1'b0, 1'b1};
    exp_seq = '{5, 4, 5};
    u_if.en = 1'b0; u_if.load = 1'b1; u_if.d = 4'd4; tick();
    u_if.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (u_if.q !== 4'd4 || u_if.tc !== 1'b0 || u_if.wrap !== 1'b0) begin
        n_fail++; $display("FAIL hold step %0d: q=%0d tc=%b wrap=%b, expected q=4 tc=0 wrap=0",
                           i, u_if.q, u_if.tc, u_if.wrap);
      end
    end
    u_if.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u_if.up_dn = dir_seq[i];
      tick();
      n_checks++;
      if (u_if.q !== 4'(exp_seq[i])) begin
        n_fail++; $display("FAIL dir_change step %0d: q=%0d, expected %0d", i, u_if.q, exp_seq[i]);
      end
    end
  endtask

  task automatic test_cascade();
    int tens_wraps;
    int exp_u;
    int exp_t;
    tens_wraps = 0;
    u_if.en = 1'b0; u_if.load = 1'b1; u_if.d = 4'd0; u_if.up_dn = 1'b1;
    t_if.load = 1'b1; t_if.d = 4'd0; t_if.up_dn = 1'b1;
    tick();
    n_checks++;
    if (u_if.q !== 4'd0 || t_if.q !== 4'd0) begin
      n_fail++; $display("FAIL cascade_clear: display=%0d%0d, expected 00", t_if.q, u_if.q);
    end
    u_if.load = 1'b0; t_if.load = 1'b0; u_if.en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      exp_u = i % 10;
      exp_t = (i / 10) % 10;
      if (t_if.wrap === 1'b1) tens_wraps++;
      n_checks++;
      if (u_if.q !== 4'(exp_u) || t_if.q !== 4'(exp_t) || t_if.wrap !== (i == 100)) begin
        n_fail++; $display("FAIL cascade step %0d: display=%0d%0d tens_wrap=%b, expected %0d%0d tens_wrap=%b",
                           i, t_if.q, u_if.q, t_if.wrap, exp_t, exp_u, (i == 100));
      end
    end
    n_checks++;
    if (tens_wraps != 1) begin
      n_fail++; $display("FAIL cascade_wrap_count: got %0d pulses, expected 1", tens_wraps);
    end
    u_if.en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_up_count();
    test_down_count();
    test_load();
    test_hold_direction();
    test_cascade();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/jk_modn_counter.md
Name: jk_modn_counter

Overview:
- Synchronous modulo-N up/down counter whose state bits are held in JK flip-flop stages, one stage per bit.
- This block is the consumer of the JK stage. It computes the per-bit J/K drive each cycle, and the JK stages hold the count.
- It sits downstream of the JK flip-flop cell as the first multi-bit sequential user of it.
- Typical uses: clock-enable dividers and BCD digit chains. Cascading is done through tc.

Parameters:
- WIDTH, 4, counter width in bits. WIDTH must be at least 1.
- MODULO, 10, count range is 0..MODULO-1. Legal range is 2 <= MODULO <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- up_dn  input  1  count direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load.
- d  input  WIDTH  load value.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational).
- wrap  output  1  one-cycle registered pulse after a wrap-around.

Behaviour:
- Reset:
  - rst_n low forces q=0 and wrap=0 immediately, with no clock needed.
  - Release is synchronous to the next clk rising edge.
  - Reset asserted mid-count aborts the count. No partial update survives.
- State storage:
  - Each bit i is a JK stage driven by j_i = k_i = toggle_i.
  - toggle_i = q_i XOR next_i, where next is the value selected by the priority rules below.
  - Hold means toggle = 0 on all bits.
- Priority per rising edge: load > en > hold.
- Load (load=1):
  - q <= d when d < MODULO.
  - q <= MODULO-1 when d >= MODULO (saturate).
  - Load ignores en and up_dn.
  - Load never asserts wrap.
- Count up (load=0, en=1, up_dn=1):
  - q <= q+1.
  - When q == MODULO-1, q <= 0 and wrap is set for the next cycle.
- Count down (load=0, en=1, up_dn=0):
  - q <= q-1.
  - When q == 0, q <= MODULO-1 and wrap is set for the next cycle.
- Hold (load=0, en=0): q unchanged and wrap <= 0.
- Latency: q updates on the same edge the control is sampled, so the new value is visible one cycle after the control is presented.
- tc = en & ~load & ((up_dn & q==MODULO-1) | (~up_dn & q==0)).
  - tc is combinational and has no register.
  - It is intended as the en input of the next cascaded digit.
- wrap:
  - Registered; goes high for exactly one cycle on the cycle after the wrapping edge.
  - It equals the tc value that was sampled at that edge.
- Out-of-range state:
  - Up from q >= MODULO, q <= 0 with wrap.
  - Down from q >= MODULO, q <= q-1 with no wrap.
  - This state is unreachable except by X at power-up; rst_n is mandatory.
- Direction change mid-count takes effect on the edge where the new up_dn is sampled. There is no dead cycle.
- MODULO == 2**WIDTH: wrap occurs at the natural rollover.
- Arithmetic is WIDTH bits, with no carry out other than tc.

Test Plan (WIDTH=4, MODULO=10):
- Reset: rst_n=0 asynchronously mid-cycle with q=7 -> q=0 and wrap=0 before the next edge; after release, q stays 0 while en=0.
- Up count: en=1, up_dn=1 for 12 edges from q=0 -> q runs 1..9,0,1,2; tc=1 only while q=9; wrap=1 for exactly the one cycle following the 9->0 edge.
- Down count: en=1, up_dn=0 from q=1 -> q runs 0,9,8; tc=1 while q=0; wrap pulses once after the 0->9 edge.
- Load: load=1 with d=5 and en=1 -> q=5 with no wrap. load=1 with d=13 -> q=9. load=1 with d=9 and en=1 at q=9 -> q=9, tc=0, no wrap.
- Hold and direction: en=0 for 3 edges at q=4 -> q stays 4 and tc=0. Then en=1 and up_dn toggling 1,0,1 -> q goes 5,4,5.
- Cascade: two instances, the tens instance with en driven by the units instance's tc, counting up from 00 for 100 edges -> display reads 99 then 00; the tens-digit wrap pulses once at the 99->00 edge.
